serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands
//  BITS_PER_CYCLE bits per clock through a chain of full-adder cells.
//  A registered carry links successive slices.
//  Start/busy/done handshake; sits between operand registers and a result
//  consumer in area-constrained datapaths.
// PARAMETERS
//  WIDTH           8  operand/result width in bits (>=2)
//  BITS_PER_CYCLE  1  bits processed per clock; must divide WIDTH exactly
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE or DONE state
//  sub       in   1      0: a+b+cin   1: a-b (a + ~b + 1, cin ignored)
//  a         in   WIDTH  operand A, captured on accepted start
//  b         in   WIDTH  operand B, captured on accepted start
//  cin       in   1      carry-in (add mode only), captured on accepted start
//  busy      out  1      high while computing (RUN state)
//  done      out  1      one-cycle pulse: result valid
//  sum       out  WIDTH  result, held from done until next accepted start
//  cout      out  1      carry-out; in sub mode 1 = no borrow (a>=b unsigned)
//  overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - STEPS = WIDTH/BITS_PER_CYCLE. Step counter width = clog2(STEPS)+1.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE --start--> RUN
//    - RUN: counter reaches STEPS-1 --> DONE
//    - DONE --start--> RUN
//    - DONE --no start--> IDLE
//  - Accepted start (edge T0):
//    - latch a; latch b (or ~b if sub).
//    - carry reg = sub ? 1 : cin.
//    - clear sum, cout and overflow; step counter = 0.
//  - RUN, each cycle:
//    - Add the low BITS_PER_CYCLE bits of A and B plus carry reg.
//    - Store the result in the top slice of the sum shift register, shifting
//      right.
//    - Shift A and B right by BITS_PER_CYCLE; carry reg = slice carry-out.
//    - On the final step, record the carry into the MSB cell for overflow.
//  - Latency: busy high T1..T(STEPS); done=1 exactly one cycle, T(STEPS+1).
//    - sum/cout/overflow are valid in that cycle and held until next start.
//  - start while busy (RUN) is ignored; operands and progress are unaffected.
//  - start during the DONE cycle is accepted (back-to-back); done still
//    pulses once for the prior result. Result outputs clear at the next edge.
//  - a/b/cin/sub changes after acceptance have no effect.
//  - Reset (any state, incl. mid-RUN): next edge -> IDLE.
//    - busy=0, done=0, sum=0, cout=0, overflow=0, counter=0, carry=0.
//    - The in-flight operation is discarded; no done pulse.
//  - Arithmetic is modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.
//  - BITS_PER_CYCLE=WIDTH gives a single RUN cycle (done at T2).
// TESTING (WIDTH=8, BITS_PER_CYCLE=1 unless noted)
//  1. start, a=8'hFF, b=8'h01, cin=0, sub=0
//     -> busy T1..T8; done only at T9; sum=8'h00, cout=1, overflow=0.
//  2. a=8'h7F, b=8'h01, cin=0, sub=0
//     -> sum=8'h80, cout=0, overflow=1.
//     Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, overflow=1.
//  3. sub=1, a=8'h05, b=8'h07, cin=1 -> sum=8'hFE, cout=0, overflow=0.
//     Then a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
//  4. Start a=8'h10, b=8'h20. Pulse start with a=8'hFF at T3; also assert
//     start in the DONE cycle with a=8'h01, b=8'h01.
//     -> first result 8'h30, exactly one done.
//     -> second op accepted; its done nine cycles after the DONE-cycle edge;
//        sum=8'h02.
//  5. rst=1 at T4 of an add -> next edge all outputs 0, IDLE, no done.
//     A fresh start then computes correctly (8'h33+8'h11 -> 8'h44).
//  6. WIDTH=4, BITS_PER_CYCLE=2: exhaustive a, b, cin, sub (1024 cases)
//     -> done 3 cycles after accept every time; sum/cout/overflow match the
//        reference model.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/handshake/result bundle for serial_adder. The master side drives a
// request and operands; the slave side (the adder) returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock through a chain
// of full-adder cells, with a registered carry linking successive slices.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    serial_adder_if.slave bus
);
    localparam int               STEPS     = WIDTH / BITS_PER_CYCLE;
    localparam int               CNT_W     = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            w_accept;
    logic                            w_step;
    logic                            w_last;

    logic [WIDTH-1:0]                r_a;
    logic [WIDTH-1:0]                r_b;
    logic [WIDTH-1:0]                r_sum;
    logic                            r_carry;
    logic                            r_cout;
    logic                            r_overflow;
    logic [CNT_W-1:0]                r_cnt;

    logic [BITS_PER_CYCLE-1:0]       w_slice_sum;
    logic [BITS_PER_CYCLE:0]         w_chain;
    logic [WIDTH+BITS_PER_CYCLE-1:0] w_sum_cat;

    // NOTE: the state register is the only place r_state changes; next-state
    // logic lives in the always_comb below with every output defaulted first
    // so no path leaves a signal unassigned (which would infer a latch).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Ripple through the slice; w_chain[i] is the carry into cell i.
    always_comb begin
        w_slice_sum = '0;
        w_chain     = '0;
        w_chain[0]  = r_carry;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_slice_sum[i] = r_a[i] ^ r_b[i] ^ w_chain[i];
            w_chain[i+1]   = (r_a[i] & r_b[i]) | (w_chain[i] & (r_a[i] ^ r_b[i]));
        end
    end

    // Concatenating first keeps the shift legal when one slice spans WIDTH.
    assign w_sum_cat = {w_slice_sum, r_sum};

    // NOTE: the datapath is reset explicitly (not just the FSM) so the result
    // outputs read zero after reset rather than a stale or partial sum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_a        <= bus.a;
            r_b        <= bus.sub ? ~bus.b : bus.b;
            r_carry    <= bus.sub | bus.cin;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> BITS_PER_CYCLE;
            r_b     <= r_b >> BITS_PER_CYCLE;
            r_carry <= w_chain[BITS_PER_CYCLE];
            r_sum   <= w_sum_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout     <= w_chain[BITS_PER_CYCLE];
                r_overflow <= w_chain[BITS_PER_CYCLE-1] ^ w_chain[BITS_PER_CYCLE];
            end
        end
    end

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit/1-bit-per-cycle instance for the
// vector table and corner sequences, plus a 4-bit/2-bit instance swept fully.
module tb_serial_adder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   timing4_bad;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Signed overflow by the sign rule, independent of the carry formulation.
    function automatic logic [5:0] ref4(input logic s, input logic [3:0] a, input logic [3:0] b,
                                        input logic c);
        logic [4:0] full;
        logic [3:0] bb;
        logic       ovf;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {4'b0, (s ? 1'b1 : c)};
        ovf  = (a[3] == bb[3]) && (full[3] != a[3]);
        return {full[4], ovf, full[3:0]};
    endfunction

    // One 8-bit operation from an idle/done DUT: timing, result, and hold.
    task automatic run8(input vec_t v, input string tag);
        int bad;
        @(negedge clk);
        bus8.sub   = v.sub;
        bus8.a     = v.a;
        bus8.b     = v.b;
        bus8.cin   = v.cin;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = ~v.a;
        bus8.b     = ~v.b;
        bus8.cin   = ~v.cin;
        bus8.sub   = ~v.sub;
        check({tag, " clear"}, {22'b0, bus8.sum, bus8.cout, bus8.overflow}, 32'h0);
        bad = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clk);
            if (bus8.busy !== (k <= 8) || bus8.done !== (k == 9)) bad++;
        end
        check({tag, " timing"}, bad, 0);
        check({tag, " sum"}, {24'b0, bus8.sum}, {24'b0, v.sum});
        check({tag, " cout"}, {31'b0, bus8.cout}, {31'b0, v.cout});
        check({tag, " ovf"}, {31'b0, bus8.overflow}, {31'b0, v.ovf});
        @(negedge clk);
        check({tag, " hold"}, {23'b0, bus8.done, bus8.sum}, {23'b0, 1'b0, v.sum});
    endtask

    task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [5:0] exp;
        exp = ref4(s, a, b, c);
        @(negedge clk);
        bus4.sub   = s;
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = c;
        bus4.start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus4.start = 1'b0;
                bus4.a     = ~a;
                bus4.b     = ~b;
                bus4.sub   = ~s;
            end
            if (bus4.busy !== (k <= 2) || bus4.done !== (k == 3)) timing4_bad++;
        end
        check($sformatf("w4 s=%0d a=%0h b=%0h c=%0d", s, a, b, c),
              {26'b0, bus4.cout, bus4.overflow, bus4.sum}, {26'b0, exp});
    endtask

    initial begin
        int bad;
        int dones;
        n_checks    = 0;
        n_fail      = 0;
        timing4_bad = 0;

        //            sub   a      b      cin   sum    cout  ovf
        vecs[0]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};

        rst = 1'b1;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset w8", {19'b0, bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.overflow}, 32'h0);
        check("reset w4", {23'b0, bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.overflow}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run8(vecs[i], $sformatf("vec%0d", i));
        end

        // Start ignored while busy, then back-to-back start in the DONE cycle.
        @(negedge clk);
        bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.a = 8'h10; bus8.b = 8'h20; bus8.start = 1'b1;
        dones = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) bus8.start = 1'b0;
            if (k == 3) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hFF;
            end
            if (k == 4) bus8.start = 1'b0;
            if (bus8.done === 1'b1) dones++;
        end
        check("b2b first done count", dones, 1);
        check("b2b first sum", {24'b0, bus8.sum}, 32'h30);
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
        bad = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus8.start = 1'b0;
                if (bus8.sum !== 8'h00) bad++;
            end
            if (bus8.busy !== (k <= 8) || bus8.done !== (k == 9)) bad++;
        end
        check("b2b second timing", bad, 0);
        check("b2b second sum", {24'b0, bus8.sum}, 32'h02);

        // Reset mid-operation discards the work and produces no done.
        @(negedge clk);
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus8.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrun reset outputs",
              {19'b0, bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.overflow}, 32'h0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) bad++;
        end
        check("midrun reset no done", bad, 0);
        run8('{1'b0, 8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0}, "after reset");

        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        run4(s[0], a[3:0], b[3:0], c[0]);
                    end
                end
            end
        end
        check("w4 timing", timing4_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
